// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions.
// Holds the 4-bit ALU_control opcode values (also used by the ALU decoder)
// and the state encoding of the execution-unit FSM.
package alu_ctrl_pkg;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluGte = 4'b0111;
  localparam logic [3:0] AluSll = 4'b1000;
  localparam logic [3:0] AluLte = 4'b1001;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } alu_state_e;

endpackage

// File: rtl/alu_exec_seq.sv
// Execution unit: single-cycle ADD/SUB/AND/OR/GTE/LTE, iterative SLL (one bit per cycle).
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   start               - request, accepted when busy is low
//   ALU_control, A, B   - opcode and operands, sampled at accept
//   result, zero        - registered result and (result == 0), held until next completion
//   busy                - multi-cycle shift in progress
//   done                - one-cycle completion pulse
module alu_exec_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_out;
  logic               accept;

  assign shamt  = B[SHAMT_W-1:0];
  assign accept = start && !busy_q;

  // One-cycle datapath; unknown codes fall through to ADD.
  always_comb begin
    alu_out = '0;
    case (ALU_control)
      AluAnd:  alu_out = A & B;
      AluOr:   alu_out = A | B;
      AluSub:  alu_out = A - B;
      AluGte:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(A) >= $signed(B))};
      // LTE code drives the branch-less-than path, hence strict compare.
      AluLte:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      AluSll:  alu_out = A << shamt;
      default: alu_out = A + B;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (ALU_control == AluSll && shamt != '0) begin
            // First bit of the shift happens at accept, so cnt holds the remaining s-1.
            acc_d   = A << 1;
            cnt_d   = shamt - 1'b1;
            busy_d  = 1'b1;
            state_d = StShift;
          end else begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            done_d   = 1'b1;
          end
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          acc_d = acc_q << 1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: scoreboard of expected results pushed at accept,
// popped and compared on each done pulse.
module tb_alu_exec_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  ALU_control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] sb[$];

  alu_exec_seq #(
    .WIDTH  (32),
    .SHAMT_W(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALU_control(ALU_control),
    .A          (A),
    .B          (B),
    .result     (result),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0110: return a - b;
      4'b0111: return {31'd0, ($signed(a) >= $signed(b))};
      4'b1001: return {31'd0, ($signed(a) < $signed(b))};
      4'b1000: return a << b[4:0];
      default: return a + b;
    endcase
  endfunction

  // Drive a request in the current time step (caller is at a negedge).
  task automatic issue_now(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start       = 1'b1;
    ALU_control = op;
    A           = a;
    B           = b;
    if (!busy) sb.push_back(model(op, a, b));
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue_now(op, a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Issue an SLL and measure busy cycles and done latency in cycles after the accept edge.
  task automatic sll_latency(input logic [31:0] a, input logic [31:0] b, input int s);
    int busy_cnt;
    int lat;
    busy_cnt = 0;
    lat      = 0;
    issue(4'b1000, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = i + 1;
        break;
      end
    end
    check("sll_latency", lat, s + 1);
    check("sll_busy_cycles", busy_cnt, s);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        check("result", result, exp);
        check("zero", {31'd0, zero}, {31'd0, (exp == 32'd0)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    start       = 1'b0;
    ALU_control = 4'b0;
    A           = '0;
    B           = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Reset in the middle of a long shift.
    issue(4'b1000, 32'd1, 32'd20);
    idle(1);
    @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    idle(25);

    // ADD/SUB wrap.
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0110, 32'd0, 32'd1);
    drain();

    // Signed compares.
    issue(4'b0111, 32'hFFFF_FFFE, 32'd3);
    issue(4'b1001, 32'hFFFF_FFFE, 32'd3);
    issue(4'b0111, 32'd5, 32'd5);
    issue(4'b1001, 32'd5, 32'd5);
    drain();

    // SLL latency, upper B bits ignored, and s=0.
    sll_latency(32'd1, 32'h24, 4);
    check("sll4_result", result, 32'h10);
    sll_latency(32'd1, 32'h0, 0);
    check("sll0_result", result, 32'h1);
    sll_latency(32'h8000_0001, 32'd31, 31);

    // Start during busy is dropped; start on the done cycle is accepted.
    issue(4'b1000, 32'd5, 32'd3);
    idle(1);
    @(negedge clk);
    check("ign_busy", {31'd0, busy}, 32'd1);
    issue_now(4'b0010, 32'd7, 32'd7);
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        k++;
      end while (!done && k < 20);
      check("ign_done_seen", {31'd0, done}, 32'd1);
    end
    issue_now(4'b0000, 32'hF0, 32'h3C);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done", {31'd0, done}, 32'd1);
    drain();
    idle(2);

    // Unknown code executes as ADD.
    issue(4'b1111, 32'd2, 32'd3);
    drain();

    // Four back-to-back ORs give four consecutive done cycles.
    for (int i = 0; i < 4; i++) begin
      issue(4'b0001, 32'h1 << i, 32'h100);
      if (i > 0) check("or_stream_done", {31'd0, done}, 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    check("or_stream_last", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("or_stream_end", {31'd0, done}, 32'd0);
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
